// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file geometry and dump FSM state encoding.
// No ports; imported by the dump reader, its beat stage, its interface and trace logic.
package rf_pkg;
   localparam int REG_SIZE     = 32;
   localparam int REGFILE_SIZE = 32;
   localparam int INDEX_SIZE   = 5;
   localparam int LAST_PAIR    = REGFILE_SIZE / 2 - 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND_A, SEND_B, DONE} rf_state_e;
endpackage

// File: rtl/rf_dump_reader_if.sv
// rf_dump_reader_if: valid/ready beat channel carrying {addr,data} register dump beats.
// Signals: valid (producer), ready (consumer), addr (register index), data (register value).
// Modports: master = producer side, slave = consumer side.
interface rf_dump_reader_if;
   import rf_pkg::*;
   logic                  valid;
   logic                  ready;
   logic [INDEX_SIZE-1:0] addr;
   logic [REG_SIZE-1:0]   data;
   modport master(output valid, addr, data, input ready);
   modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/rf_dump_beat_reg.sv
// rf_dump_beat_reg: two-entry capture of an even/odd register pair plus the valid/ready output stage.
// Ports: clock, reset_n (async active-low), clear (drop everything), capture (load pair),
//   base (even index of the pair), cap_in_a/cap_in_b (rf outA/outB),
//   fire_a/fire_b (handshake of the even/odd beat), dump (master side of the beat channel).
module rf_dump_beat_reg
   import rf_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  capture,
   input  logic [INDEX_SIZE-1:0] base,
   input  logic [REG_SIZE-1:0]   cap_in_a,
   input  logic [REG_SIZE-1:0]   cap_in_b,
   output logic                  fire_a,
   output logic                  fire_b,
   rf_dump_reader_if.master      dump
);
   logic [REG_SIZE-1:0]   cap_a, cap_b;
   logic [INDEX_SIZE-1:0] base_q;
   logic                  sel, valid;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         cap_a  <= '0;
         cap_b  <= '0;
         base_q <= '0;
         sel    <= 1'b0;
         valid  <= 1'b0;
      end else if (clear) begin
         cap_a  <= '0;
         cap_b  <= '0;
         base_q <= '0;
         sel    <= 1'b0;
         valid  <= 1'b0;
      end else if (capture) begin
         cap_a  <= cap_in_a;
         cap_b  <= cap_in_b;
         base_q <= base;
         sel    <= 1'b0;
         valid  <= 1'b1;
      end else if (fire_a)
         sel <= 1'b1;
      else if (fire_b)
         valid <= 1'b0;
   always_comb begin
      fire_a = valid & dump.ready & ~sel;
      fire_b = valid & dump.ready & sel;
   end
   // base is always even, so OR-ing sel selects the odd partner
   assign dump.valid = valid;
   assign dump.addr  = base_q | INDEX_SIZE'(sel);
   assign dump.data  = sel ? cap_b : cap_a;
endmodule

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks the register file pairwise over both read ports and streams every register out.
// Ports: clock, reset_n (async active-low), start, abort,
//   read_addr_s/read_addr_t (even/odd rf read addresses), rf_outA/rf_outB (rf read data),
//   dump (master side of the beat channel), busy (not IDLE), finish (one-cycle end pulse).
module rf_dump_reader
   import rf_pkg::*;
#(
   parameter int RD_LATENCY = 1
)(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   output logic [INDEX_SIZE-1:0] read_addr_s,
   output logic [INDEX_SIZE-1:0] read_addr_t,
   input  logic [REG_SIZE-1:0]   rf_outA,
   input  logic [REG_SIZE-1:0]   rf_outB,
   rf_dump_reader_if.master      dump,
   output logic                  busy,
   output logic                  finish
);
   localparam int LAT_W = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
   rf_state_e             state;
   logic [INDEX_SIZE-2:0] pair;
   logic [LAT_W-1:0]      lat;
   logic                  capture, fire_a, fire_b;
   assign capture = state == WAIT && lat == LAT_W'(RD_LATENCY - 1);
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state       <= IDLE;
         pair        <= '0;
         lat         <= '0;
         read_addr_s <= '0;
         read_addr_t <= '0;
         busy        <= 1'b0;
         finish      <= 1'b0;
      end else if (abort) begin
         state  <= IDLE;
         pair   <= '0;
         lat    <= '0;
         busy   <= 1'b0;
         finish <= 1'b0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  state       <= ISSUE;
                  busy        <= 1'b1;
                  read_addr_s <= {pair, 1'b0};
                  read_addr_t <= {pair, 1'b1};
               end
            ISSUE: begin
               state <= WAIT;
               lat   <= '0;
            end
            WAIT:
               if (capture) state <= SEND_A;
               else lat <= lat + 1'b1;
            SEND_A:
               if (fire_a) state <= SEND_B;
            SEND_B:
               if (fire_b) begin
                  if (pair == (INDEX_SIZE-1)'(LAST_PAIR)) begin
                     state  <= DONE;
                     finish <= 1'b1;
                  end else begin
                     state       <= ISSUE;
                     pair        <= pair + 1'b1;
                     read_addr_s <= {pair + 1'b1, 1'b0};
                     read_addr_t <= {pair + 1'b1, 1'b1};
                  end
               end
            DONE: begin
               state  <= IDLE;
               pair   <= '0;
               busy   <= 1'b0;
               finish <= 1'b0;
            end
            default: state <= IDLE;
         endcase
   rf_dump_beat_reg beat_reg (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (abort),
      .capture  (capture),
      .base     (read_addr_s),
      .cap_in_a (rf_outA),
      .cap_in_b (rf_outB),
      .fire_a   (fire_a),
      .fire_b   (fire_b),
      .dump     (dump)
   );
endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: directed bench for rf_dump_reader with a preloaded 32x32 register file model.
// No ports.
module tb_rf_dump_reader;
   import rf_pkg::*;
   logic                  clock = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [INDEX_SIZE-1:0] read_addr_s, read_addr_t;
   logic [REG_SIZE-1:0]   rf_outA = '0;
   logic [REG_SIZE-1:0]   rf_outB = '0;
   logic                  busy, finish;
   logic [REG_SIZE-1:0]   regs [REGFILE_SIZE];
   int                    n_assert = 0;
   int                    n_fail = 0;
   rf_dump_reader_if dump();
   rf_dump_reader dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .read_addr_s (read_addr_s),
      .read_addr_t (read_addr_t),
      .rf_outA     (rf_outA),
      .rf_outB     (rf_outB),
      .dump        (dump),
      .busy        (busy),
      .finish      (finish)
   );
   always #5 clock = ~clock;
   // rf_32 model: reads on negedge, register 0 reads as zero
   always @(negedge clock) begin
      rf_outA <= read_addr_s == '0 ? '0 : regs[read_addr_s];
      rf_outB <= read_addr_t == '0 ? '0 : regs[read_addr_t];
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   function automatic logic [31:0] expv(input int i);
      return i == 0 ? 32'h0 : 32'hA5000000 + 32'(i);
   endfunction
   // mode 0: ready high; 1: ready 1-of-3; 2: overwrite reg 4 after its pair is captured; 3: stray start at beat 7
   task automatic run_dump(input int mode, input string tag);
      int                    beat = 0;
      int                    cyc = 0;
      logic                  held = 1'b0;
      logic [INDEX_SIZE-1:0] ha = '0;
      logic [REG_SIZE-1:0]   hd = '0;
      start = 1'b1;
      step;
      start = 1'b0;
      chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      while (beat < 32 && cyc < 400) begin
         if (held) begin
            chk({tag, " hold_valid"}, 32'(dump.valid), 32'd1);
            chk({tag, " hold_addr"}, 32'(dump.addr), 32'(ha));
            chk({tag, " hold_data"}, dump.data, hd);
         end
         dump.ready = (mode != 1) || (cyc % 3 == 0);
         start = (mode == 3) && (beat == 7);
         if (mode == 2 && dump.valid && dump.addr == 5'd4) regs[4] = 32'hDEADBEEF;
         if (dump.valid && dump.ready) begin
            chk({tag, " beat_addr"}, 32'(dump.addr), 32'(beat));
            chk({tag, " beat_data"}, dump.data, expv(beat));
            beat++;
         end
         held = dump.valid && !dump.ready;
         ha = dump.addr;
         hd = dump.data;
         step;
         cyc++;
      end
      start = 1'b0;
      chk({tag, " beat_count"}, 32'(beat), 32'd32);
      if (mode != 1) chk({tag, " cycles"}, 32'(cyc), 32'd64);
      chk({tag, " finish_pulse"}, 32'(finish), 32'd1);
      chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
      chk({tag, " valid_in_done"}, 32'(dump.valid), 32'd0);
      step;
      chk({tag, " finish_cleared"}, 32'(finish), 32'd0);
      chk({tag, " busy_cleared"}, 32'(busy), 32'd0);
      if (mode == 2) regs[4] = expv(4);
   endtask
   initial begin
      int found;
      int fins;
      for (int i = 0; i < REGFILE_SIZE; i++) regs[i] = 32'hA5000000 + 32'(i);
      dump.ready = 1'b0;
      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset finish", 32'(finish), 32'd0);
      chk("reset valid", 32'(dump.valid), 32'd0);
      chk("reset addr", 32'(dump.addr), 32'd0);
      chk("reset data", dump.data, 32'd0);
      chk("reset addr_s", 32'(read_addr_s), 32'd0);
      chk("reset addr_t", 32'(read_addr_t), 32'd0);
      reset_n = 1'b1;
      step;
      abort = 1'b1;
      start = 1'b1;
      step;
      abort = 1'b0;
      start = 1'b0;
      chk("abort_wins_idle busy", 32'(busy), 32'd0);
      step;
      chk("abort_wins_idle busy_later", 32'(busy), 32'd0);
      run_dump(0, "t1");
      run_dump(1, "t2");
      start = 1'b1;
      step;
      start = 1'b0;
      dump.ready = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (dump.valid && dump.addr == 5'd11) found = 1;
         else step;
      end
      chk("t3 reached_addr11", 32'(found), 32'd1);
      dump.ready = 1'b0;
      abort = 1'b1;
      step;
      abort = 1'b0;
      chk("t3 valid_after_abort", 32'(dump.valid), 32'd0);
      chk("t3 busy_after_abort", 32'(busy), 32'd0);
      chk("t3 finish_after_abort", 32'(finish), 32'd0);
      fins = 0;
      repeat (4) begin
         step;
         fins += int'(finish);
      end
      chk("t3 no_finish", 32'(fins), 32'd0);
      run_dump(0, "t3_restart");
      run_dump(3, "t4");
      fins = 0;
      repeat (10) begin
         step;
         fins += int'(finish);
      end
      chk("t4 single_finish", 32'(fins), 32'd0);
      chk("t4 idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      step;
      start = 1'b0;
      dump.ready = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (read_addr_s == 5'd18 && busy && !dump.valid) found = 1;
         else step;
      end
      chk("t5 reached_pair9", 32'(found), 32'd1);
      step;
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5 reset busy", 32'(busy), 32'd0);
      chk("t5 reset finish", 32'(finish), 32'd0);
      chk("t5 reset valid", 32'(dump.valid), 32'd0);
      chk("t5 reset addr", 32'(dump.addr), 32'd0);
      chk("t5 reset data", dump.data, 32'd0);
      chk("t5 reset addr_s", 32'(read_addr_s), 32'd0);
      chk("t5 reset addr_t", 32'(read_addr_t), 32'd0);
      reset_n = 1'b1;
      step;
      run_dump(0, "t5_fresh");
      run_dump(2, "t6");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
